// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: fetch FSM states, the nop encoding and the default reset vector.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    KILL = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection for the fetch stage: redirect detection, target mux and sequential PC+4.
module fetch_next_pc (
  input  logic        i_pc_jump,
  input  logic        i_pc_src,
  input  logic [31:0] i_jump_tgt,
  input  logic [31:0] i_branch_tgt,
  input  logic [31:0] i_pc,
  output logic        o_redirect,
  output logic [31:0] o_target,
  output logic [31:0] o_pc_plus4
);

  // Jump wins over a taken branch when decode asserts both.
  assign o_redirect = i_pc_jump | i_pc_src;
  assign o_target   = i_pc_jump ? i_jump_tgt : i_branch_tgt;
  assign o_pc_plus4 = i_pc + 32'd4;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage with one outstanding imem request and the IF/ID register.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_StallD,
  input  logic        i_FlushD,
  input  logic        i_PCSrcD,
  input  logic [31:0] i_PCBranchD,
  input  logic        i_JumpD,
  input  logic [31:0] i_PCJumpD,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_InstrD,
  output logic [5:0]  o_OpD,
  output logic [5:0]  o_functD,
  output logic [31:0] o_PCPlus4D,
  output logic        o_ValidD
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] o_fetch_cnt,
  output logic [15:0] o_discard_cnt
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_q, hold_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pcplus4_q, pcplus4_d;
  logic         valid_q, valid_d;

  logic         redirect;
  logic [31:0]  target;
  logic [31:0]  pc_plus4;
  logic         req;
  logic [31:0]  addr;
  logic         has_word;
  logic [31:0]  word;
  logic         discard;
  logic         word_wr;

  fetch_next_pc u_next_pc (
    .i_pc_jump    (i_JumpD),
    .i_pc_src     (i_PCSrcD),
    .i_jump_tgt   (i_PCJumpD),
    .i_branch_tgt (i_PCBranchD),
    .i_pc         (pc_q),
    .o_redirect   (redirect),
    .o_target     (target),
    .o_pc_plus4   (pc_plus4)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    hold_d   = hold_q;
    req      = 1'b0;
    addr     = pc_q;
    has_word = 1'b0;
    word     = i_imem_rdata;
    discard  = 1'b0;
    case (state_q)
      IDLE: begin
        req     = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (i_imem_rvalid) begin
          if (redirect) begin
            discard = 1'b1;
            req     = 1'b1;
            addr    = target;
            pc_d    = target;
          end else if (i_StallD && !i_FlushD) begin
            hold_d  = i_imem_rdata;
            state_d = HOLD;
          end else begin
            has_word = 1'b1;
            req      = 1'b1;
            addr     = pc_plus4;
            pc_d     = pc_plus4;
          end
        end else if (redirect) begin
          pc_d    = target;
          state_d = KILL;
        end
      end
      KILL: begin
        // The in-flight response belongs to the old path; refetch from the latest target.
        if (i_imem_rvalid) begin
          discard = 1'b1;
          req     = 1'b1;
          addr    = redirect ? target : pc_q;
          pc_d    = redirect ? target : pc_q;
          state_d = WAIT;
        end else if (redirect) begin
          pc_d = target;
        end
      end
      HOLD: begin
        if (redirect) begin
          req     = 1'b1;
          addr    = target;
          pc_d    = target;
          state_d = WAIT;
        end else if (!i_StallD && !i_FlushD) begin
          has_word = 1'b1;
          word     = hold_q;
          req      = 1'b1;
          addr     = pc_plus4;
          pc_d     = pc_plus4;
          state_d  = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    instr_d   = instr_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    word_wr   = 1'b0;
    if (i_FlushD) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (i_StallD) begin
      instr_d = instr_q;
    end else if (has_word) begin
      instr_d   = word;
      pcplus4_d = pc_plus4;
      valid_d   = 1'b1;
      word_wr   = 1'b1;
    end else begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      pcplus4_q <= 32'h0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pcplus4_q <= pcplus4_d;
      valid_q   <= valid_d;
    end
  end

  always_ff @(posedge i_clk) begin
    hold_q <= hold_d;
  end

  // Held in reset, IDLE must not leak its request pulse.
  assign o_imem_req  = req & i_rst_n;
  assign o_imem_addr = addr;
  assign o_InstrD    = instr_q;
  assign o_OpD       = instr_q[31:26];
  assign o_functD    = instr_q[5:0];
  assign o_PCPlus4D  = pcplus4_q;
  assign o_ValidD    = valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] discard_cnt_q, discard_cnt_d;

  always_comb begin
    fetch_cnt_d   = fetch_cnt_q;
    discard_cnt_d = discard_cnt_q;
    if (word_wr) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (discard && discard_cnt_q != 16'hFFFF) discard_cnt_d = discard_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fetch_cnt_q   <= 32'h0;
      discard_cnt_q <= 16'h0;
    end else begin
      fetch_cnt_q   <= fetch_cnt_d;
      discard_cnt_q <= discard_cnt_d;
    end
  end

  assign o_fetch_cnt   = fetch_cnt_q;
  assign o_discard_cnt = discard_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; counter checks run when FETCH_PERF_CNT_EN is defined.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, pcsrc, jump;
  logic [31:0] pcbranch, pcjump;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        rvalid;
  logic [31:0] rdata;
  logic [31:0] instr_d;
  logic [5:0]  op_d, funct_d;
  logic [31:0] pcplus4_d;
  logic        valid_d;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [15:0] discard_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_StallD      (stall),
    .i_FlushD      (flush),
    .i_PCSrcD      (pcsrc),
    .i_PCBranchD   (pcbranch),
    .i_JumpD       (jump),
    .i_PCJumpD     (pcjump),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_rvalid (rvalid),
    .i_imem_rdata  (rdata),
    .o_InstrD      (instr_d),
    .o_OpD         (op_d),
    .o_functD      (funct_d),
    .o_PCPlus4D    (pcplus4_d),
    .o_ValidD      (valid_d)
`ifdef FETCH_PERF_CNT_EN
    ,
    .o_fetch_cnt   (fetch_cnt),
    .o_discard_cnt (discard_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_req(input string tag, input logic r, input logic [31:0] a);
    chk({tag, "_req"}, 32'(imem_req), 32'(r));
    if (r) chk({tag, "_addr"}, imem_addr, a);
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] i, input logic [31:0] p4, input logic v);
    chk({tag, "_instr"}, instr_d, i);
    chk({tag, "_pc4"}, pcplus4_d, p4);
    chk({tag, "_valid"}, 32'(valid_d), 32'(v));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    stall    = 1'b0;
    flush    = 1'b0;
    pcsrc    = 1'b0;
    jump     = 1'b0;
    pcbranch = 32'h0;
    pcjump   = 32'h0;
    rvalid   = 1'b0;
    rdata    = 32'h0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_in();
    #2;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk_ifid("rst", 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // IDLE cycle: request at reset vector
    #1 chk_req("idle", 1'b1, 32'h0);
    tick();

    // single-cycle memory, back-to-back words
    idle_in(); rvalid = 1'b1; rdata = 32'h2008_0005;
    #1 chk_req("w0", 1'b1, 32'h4);
    tick();
    chk_ifid("w0", 32'h2008_0005, 32'h4, 1'b1);
    chk("w0_op", 32'(op_d), 32'h08);

    idle_in(); rvalid = 1'b1; rdata = 32'h2009_0007;
    #1 chk_req("w1", 1'b1, 32'h8);
    tick();
    chk_ifid("w1", 32'h2009_0007, 32'h8, 1'b1);
    chk("w1_funct", 32'(funct_d), 32'h07);

    // stall for 4 cycles starting with the response for 0x8
    idle_in(); rvalid = 1'b1; rdata = 32'h012A_4020; stall = 1'b1;
    #1 chk_req("stall0", 1'b0, 32'h0);
    tick();
    chk_ifid("stall0", 32'h2009_0007, 32'h8, 1'b1);
    for (int i = 1; i < 4; i++) begin
      idle_in(); stall = 1'b1;
      #1 chk_req("stallN", 1'b0, 32'h0);
      tick();
      chk_ifid("stallN", 32'h2009_0007, 32'h8, 1'b1);
    end
    idle_in();
    #1 chk_req("release", 1'b1, 32'hC);
    tick();
    chk_ifid("release", 32'h012A_4020, 32'hC, 1'b1);

    // 3-cycle latency: no request and bubbles until the response
    for (int i = 0; i < 2; i++) begin
      idle_in();
      #1 chk_req("lat_gap", 1'b0, 32'h0);
      tick();
      chk("lat_gap_valid", 32'(valid_d), 32'd0);
    end
    idle_in(); rvalid = 1'b1; rdata = 32'h8D0B_0004;
    #1 chk_req("lat_resp", 1'b1, 32'h10);
    tick();
    chk_ifid("lat_resp", 32'h8D0B_0004, 32'h10, 1'b1);
    chk("lat_op", 32'(op_d), 32'h23);

    // jump and branch together while request for 0x10 is in flight
    idle_in(); jump = 1'b1; pcjump = 32'h100; pcsrc = 1'b1; pcbranch = 32'h40;
    #1 chk_req("kill0", 1'b0, 32'h0);
    tick();
    chk("kill0_valid", 32'(valid_d), 32'd0);
    idle_in();
    #1 chk_req("kill1", 1'b0, 32'h0);
    tick();
    idle_in(); rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    #1 chk_req("kill_resp", 1'b1, 32'h100);
    tick();
    chk("kill_valid", 32'(valid_d), 32'd0);
    chk("kill_instr", instr_d, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("discard_after_jump", 32'(discard_cnt), 32'd1);
    chk("fetch_after_jump", fetch_cnt, 32'd4);
`endif

    idle_in(); rvalid = 1'b1; rdata = 32'h0109_5020;
    #1 chk_req("tgt_word", 1'b1, 32'h104);
    tick();
    chk_ifid("tgt_word", 32'h0109_5020, 32'h104, 1'b1);

    // response, branch redirect and flush in one cycle
    idle_in(); rvalid = 1'b1; rdata = 32'h2222_2222; pcsrc = 1'b1; pcbranch = 32'h40; flush = 1'b1;
    #1 chk_req("rflush", 1'b1, 32'h40);
    tick();
    chk_ifid("rflush", 32'h0, 32'h104, 1'b0);

`ifdef FETCH_PERF_CNT_EN
    for (int i = 0; i < 70000; i++) begin
      idle_in(); rvalid = 1'b1; pcsrc = 1'b1; pcbranch = 32'h40;
      tick();
    end
    chk("discard_sat", 32'(discard_cnt), 32'h0000_FFFF);
`endif

    // reset while a request is outstanding, stale response arrives in IDLE
    idle_in();
    #1 rst_n = 1'b0;
    #1 chk("mid_rst_req", 32'(imem_req), 32'd0);
    chk_ifid("mid_rst", 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    chk("mid_rst_discard", 32'(discard_cnt), 32'd0);
`endif
    tick();
    rst_n = 1'b1;
    rvalid = 1'b1; rdata = 32'h3333_3333;
    #1 chk_req("idle2", 1'b1, 32'h0);
    tick();
    chk("idle2_valid", 32'(valid_d), 32'd0);
    idle_in(); rvalid = 1'b1; rdata = 32'h2008_0005;
    #1 chk_req("restart", 1'b1, 32'h4);
    tick();
    chk_ifid("restart", 32'h2008_0005, 32'h4, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
